// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, 32x32 -> 64, signed or unsigned, one Booth digit per cycle.
// Optional early termination is enabled by defining BOOTH_MUL_EARLY_TERM_EN.

module booth_digit_sel (
  input  logic [2:0] triple_i,
  output logic       neg_o,
  output logic       one_o,
  output logic       two_o
);
  always_comb begin
    neg_o = 1'b0;
    one_o = 1'b0;
    two_o = 1'b0;
    case (triple_i)
      3'b001, 3'b010: one_o = 1'b1;
      3'b011:         two_o = 1'b1;
      3'b100:         begin two_o = 1'b1; neg_o = 1'b1; end
      3'b101, 3'b110: begin one_o = 1'b1; neg_o = 1'b1; end
      default:        ;
    endcase
  end
endmodule

module booth_seq_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  input  logic        Sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [65:0] a_q, a_d;       // multiplicand extended to accumulator width
  logic [34:0] mx_q, mx_d;     // {m[33:0], m[-1]}; bit i holds m[i-1]
  logic        sign_q, sign_d;
  logic [65:0] acc_q, acc_d;
  logic [4:0]  k_q, k_d;
  logic [63:0] prod_q, prod_d;

  logic [65:0] a_ext;
  logic [34:0] mx_in;
  logic [2:0]  triple;
  logic        dg_neg, dg_one, dg_two;
  logic [65:0] mult, addend, acc_sum;
  logic [4:0]  k_last;
  logic        et_accept, et_calc;

  assign a_ext  = Sign ? {{34{Multiplicand[31]}}, Multiplicand} : {34'd0, Multiplicand};
  assign mx_in  = Sign ? {{2{Multiplier[31]}}, Multiplier, 1'b0} : {2'b00, Multiplier, 1'b0};
  assign k_last = sign_q ? 5'd15 : 5'd16;
  assign triple = mx_q[{k_q, 1'b0} +: 3];

  booth_digit_sel u_sel (
    .triple_i (triple),
    .neg_o    (dg_neg),
    .one_o    (dg_one),
    .two_o    (dg_two)
  );

  // Negate before shifting so the two's complement addend stays exact mod 2^66.
  always_comb begin
    mult = 66'd0;
    if (dg_two)      mult = a_q << 1;
    else if (dg_one) mult = a_q;
    addend  = (dg_neg ? (~mult + 66'd1) : mult) << {k_q, 1'b0};
    acc_sum = acc_q + addend;
  end

`ifdef BOOTH_MUL_EARLY_TERM_EN
  logic signed [34:0] rem_s;
  // Remaining bits m[33:2k+1] after this digit; arithmetic shift keeps them padded with m[33].
  assign rem_s     = $signed(mx_q) >>> ({1'b0, k_q, 1'b0} + 7'd2);
  assign et_calc   = (rem_s == '0) || (rem_s == '1);
  assign et_accept = (mx_in == '0) || (mx_in == '1);
`else
  assign et_calc   = 1'b0;
  assign et_accept = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mx_d    = mx_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    k_d     = k_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_ext;
          mx_d    = mx_in;
          sign_d  = Sign;
          acc_d   = 66'd0;
          k_d     = 5'd0;
          state_d = CALC;
          if (et_accept) begin
            prod_d  = 64'd0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d = acc_sum;
        k_d   = k_q + 5'd1;
        if ((k_q == k_last) || et_calc) begin
          prod_d  = acc_sum[63:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 66'd0;
      mx_q    <= 35'd0;
      sign_q  <= 1'b0;
      acc_q   <= 66'd0;
      k_q     <= 5'd0;
      prod_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mx_q    <= mx_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Product   = prod_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: expected product/latency queued at accept, checked at output.
module tb_booth_seq_multiplier;
  logic        clk, rst_n, in_valid, in_ready, Sign, out_valid, out_ready, busy;
  logic [31:0] Multiplicand, Multiplier;
  logic [63:0] Product;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  booth_seq_multiplier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Sign         (Sign),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Product      (Product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ae, be;
    ae = s ? {{32{a[31]}}, a} : {32'd0, a};
    be = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ae * be;
  endfunction

  // Edges from the accept edge until out_valid is seen (equals the number of CALC cycles).
  function automatic int model_lat(input logic [31:0] b, input logic s);
    int n;
`ifdef BOOTH_MUL_EARLY_TERM_EN
    logic [33:0] m;
    bit          uni;
`endif
    n = s ? 16 : 17;
`ifdef BOOTH_MUL_EARLY_TERM_EN
    m = s ? {{2{b[31]}}, b} : {2'b00, b};
    if (m == 34'd0) return 0;
    for (int k = 0; k < n; k++) begin
      uni = 1'b1;
      for (int j = 2*k + 1; j <= 33; j++)
        if (m[j] != m[33]) uni = 1'b0;
      if (uni || k == n - 1) return k + 1;
    end
`endif
    return n;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, input bit poke, input bit no_sync);
    exp_t e;
    int   lat;
    if (!no_sync) @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    Multiplicand = a; Multiplier = b; Sign = s; in_valid = 1'b1;
    e.prod = model_prod(a, b, s);
    e.lat  = model_lat(b, s);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("accepted_busy", {63'd0, busy}, 64'd1);
    if (poke) begin
      Multiplicand = ~a; Multiplier = ~b; Sign = ~s;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    e = sb.pop_front();
    chk("latency", 64'(lat), 64'(e.lat));
    chk("product", Product, e.prod);
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_product", Product, e.prod);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    // Offer new operands on the DONE->IDLE edge; they must not be taken.
    out_ready = 1'b1;
    in_valid = 1'b1; Multiplicand = 32'h5; Multiplier = 32'h7; Sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_valid", {63'd0, out_valid}, 64'd0);
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_product", Product, e.prod);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t d;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Multiplicand = 32'd0; Multiplier = 32'd0; Sign = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_product", Product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'h00000003, 1'b1, 0, 0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 0, 0, 0);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 5, 0, 0);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1, 0);
    run_op(32'h00000000, 32'hDEADBEEF, 1'b0, 0, 0, 0);
    run_op(32'hCAFEF00D, 32'h00000000, 1'b1, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0, 0);
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 1, 0, 0);

    // Reset mid-CALC at k=7: no output, immediate return to idle.
    @(negedge clk);
    Multiplicand = 32'h12345678; Multiplier = 32'h9ABCDEF0; Sign = 1'b0; in_valid = 1'b1;
    d.prod = model_prod(32'h12345678, 32'h9ABCDEF0, 1'b0);
    d.lat  = 17;
    sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    d = sb.pop_back();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_product", Product, 64'd0);
    #1;
    rst_n = 1'b1;
    run_op(32'd3, 32'd5, 1'b0, 0, 0, 1);

`ifdef BOOTH_MUL_EARLY_TERM_EN
    run_op(32'h00001234, 32'h00000002, 1'b0, 0, 0, 0);
    run_op(32'h00001234, 32'h00000000, 1'b0, 0, 0, 0);
`endif

    for (int i = 0; i < 12; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 0, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
